spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync.sv | 24 ++
 rtl/spi_slave.sv | 134 +++++++++++++
 tb/tb_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and clock-mode constants
// used by both the master and slave blocks.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

  localparam bit CPOL_IDLE_LOW     = 1'b0;
  localparam bit CPOL_IDLE_HIGH    = 1'b1;
  localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a
// selectable reset level so the idle state is seen out of reset.
module spi_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples sclk/ss_n/mosi in the clk domain, shifts one
// DATA_W word per frame slot with a single-entry transmit buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          CPOL   = CPOL_IDLE_LOW,
  parameter bit          CPHA   = CPHA_SAMPLE_LEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_q, ss_n_q;
  logic [1:0] settle;

  spi_sync #(.RST_VAL(CPOL))  u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b1))  u_sync_ss   (.clk(clk), .rst(rst), .d(ss_n), .q(ss_n_s));
  spi_sync #(.RST_VAL(1'b0))  u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_buf, load_word;
  logic              und_pend;
  logic              lead, trail, sample, shift, last, ss_fall, load;

  // Edge strobes and next-state decode
  always_comb begin
    state_nxt = state;
    lead      = (sclk_q == CPOL) && (sclk_s != CPOL);
    trail     = (sclk_q != CPOL) && (sclk_s == CPOL);
    ss_fall   = ss_n_q && !ss_n_s;
    sample    = (state == ST_SHIFT) && !ss_n_s && (CPHA ? trail : lead);
    // In mode 0 the trailing edge right after a word's last sample belongs
    // to that word, so it must not shift the freshly loaded next word.
    shift     = (state == ST_SHIFT) && (CPHA ? lead : (trail && (bit_cnt != '0)));
    last      = sample && (bit_cnt == LAST_BIT);
    load      = (state == ST_LOAD) && !ss_n_s;
    load_word = tx_ready ? '0 : tx_buf;

    if (ss_n_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (ss_fall) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_SHIFT;
        ST_SHIFT: if (last) state_nxt = ST_LOAD;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sclk_q      <= CPOL;
      ss_n_q      <= 1'b0;
      settle      <= 2'b00;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_buf      <= '0;
      und_pend    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      sclk_q      <= sclk_s;
      settle      <= {settle[0], 1'b1};
      // Hold the ss_n history low until the synchronizer has flushed its
      // reset value, so a level held low through reset is not a fall.
      ss_n_q      <= settle[1] ? ss_n_s : 1'b0;
      busy        <= (state_nxt != ST_IDLE);
      miso_oe     <= !ss_n_s;
      rx_valid    <= last;
      tx_underrun <= 1'b0;

      if (state_nxt == ST_IDLE) begin
        bit_cnt  <= '0;
        rx_sr    <= '0;
        und_pend <= 1'b0;
        miso     <= 1'b0;
      end else if (state == ST_LOAD) begin
        bit_cnt  <= '0;
        und_pend <= tx_ready;
        tx_sr    <= CPHA ? load_word : {load_word[DATA_W-2:0], 1'b0};
        if (!CPHA) miso <= load_word[DATA_W-1];
      end else begin
        if (sample) begin
          rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
          bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
          if (last) rx_data <= {rx_sr[DATA_W-2:0], mosi_s};
        end
        if (shift) begin
          miso  <= tx_sr[DATA_W-1];
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
        // Underrun is flagged when the empty-loaded word actually starts
        if (lead && und_pend) begin
          tx_underrun <= 1'b1;
          und_pend    <= 1'b0;
        end
      end

      if (load) tx_ready <= 1'b1;
      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master, with a scoreboard on received words.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int W = 8;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  logic sclk, ss0, ss3, mosi;
  logic [W-1:0] tx_data;
  logic tx_load0, tx_load3;
  logic miso0, miso_oe0, tx_ready0, rx_valid0, busy0, und0;
  logic miso3, miso_oe3, tx_ready3, rx_valid3, busy3, und3;
  logic [W-1:0] rx_data0, rx_data3;

  int errors = 0;
  int checks = 0;
  int rxv_cnt0 = 0, rxv_cnt3 = 0, und_cnt0 = 0, und_cnt3 = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q3[$];
  logic [W-1:0] e0, e3;
  bit cpol_m, cpha_m;
  int sel;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(W), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss0), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .tx_load(tx_load0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .busy(busy0), .tx_underrun(und0));

  spi_slave #(.DATA_W(W), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss3), .mosi(mosi),
    .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data), .tx_load(tx_load3),
    .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .busy(busy3), .tx_underrun(und3));

  // Scoreboard: every rx_valid pulse must match the next expected word
  always @(negedge clk) begin
    if (rx_valid0) begin
      rxv_cnt0++;
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL rx0_unexpected: rx_data=%h with no word expected", rx_data0);
      end else begin
        e0 = exp_q0.pop_front();
        if (rx_data0 !== e0) begin
          errors++;
          $display("FAIL rx0_word: got %h expected %h", rx_data0, e0);
        end
      end
    end
    if (rx_valid3) begin
      rxv_cnt3++;
      checks++;
      if (exp_q3.size() == 0) begin
        errors++;
        $display("FAIL rx3_unexpected: rx_data=%h with no word expected", rx_data3);
      end else begin
        e3 = exp_q3.pop_front();
        if (rx_data3 !== e3) begin
          errors++;
          $display("FAIL rx3_word: got %h expected %h", rx_data3, e3);
        end
      end
    end
    if (und0) und_cnt0++;
    if (und3) und_cnt3++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load_tx(input int s, input logic [W-1:0] d);
    logic rdy;
    tx_data = d;
    if (s == 0) tx_load0 = 1'b1; else tx_load3 = 1'b1;
    wait_clk(1);
    tx_load0 = 1'b0;
    tx_load3 = 1'b0;
    rdy = (s == 0) ? tx_ready0 : tx_ready3;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_clear: got %b expected 0", rdy);
    end
  endtask

  task automatic start_frame();
    if (sel == 0) ss0 = 1'b0; else ss3 = 1'b0;
    wait_clk(8);
  endtask

  task automatic end_frame();
    wait_clk(H);
    ss0 = 1'b1;
    ss3 = 1'b1;
    wait_clk(8);
  endtask

  task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = W - 1 - k;
      if (!cpha_m) begin
        mosi = mo[i];
        wait_clk(H);
        mi[i] = (sel == 0) ? miso0 : miso3;
        sclk = ~cpol_m;
        wait_clk(H);
        sclk = cpol_m;
      end else begin
        sclk = ~cpol_m;
        mosi = mo[i];
        wait_clk(H);
        mi[i] = (sel == 0) ? miso0 : miso3;
        sclk = cpol_m;
        wait_clk(H);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; ss0 = 1'b1; ss3 = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load0 = 1'b0; tx_load3 = 1'b0;
    wait_clk(3);
    chk("reset_ctl0", W'({miso0, miso_oe0, tx_ready0, rx_valid0, busy0, und0}), W'(6'b001000));
    chk("reset_rx0", rx_data0, '0);
    chk("reset_ctl3", W'({miso3, miso_oe3, tx_ready3, rx_valid3, busy3, und3}), W'(6'b001000));
    chk("reset_rx3", rx_data3, '0);
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_mode0();
    logic [W-1:0] got;
    int r0, u0;
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0; sclk = 1'b0;
    r0 = rxv_cnt0; u0 = und_cnt0;
    load_tx(0, 8'hA5);
    exp_q0.push_back(8'h3C);
    start_frame();
    chk("m0_busy_oe", W'({busy0, miso_oe0}), W'(2'b11));
    xfer(8'h3C, 8, got);
    end_frame();
    chk("m0_miso_word", got, 8'hA5);
    chk("m0_rx_data", rx_data0, 8'h3C);
    chk("m0_rx_pulses", W'(rxv_cnt0 - r0), W'(1));
    chk("m0_underruns", W'(und_cnt0 - u0), W'(0));
    chk("m0_idle_outs", W'({busy0, miso0, miso_oe0, tx_ready0}), W'(4'b0001));
  endtask

  task automatic test_mode3();
    logic [W-1:0] got;
    int r3, u3;
    sel = 3; cpol_m = 1'b1; cpha_m = 1'b1; sclk = 1'b1;
    wait_clk(4);
    r3 = rxv_cnt3; u3 = und_cnt3;
    load_tx(3, 8'h7E);
    exp_q3.push_back(8'h81);
    start_frame();
    xfer(8'h81, 8, got);
    end_frame();
    chk("m3_miso_word", got, 8'h7E);
    chk("m3_rx_data", rx_data3, 8'h81);
    chk("m3_rx_pulses", W'(rxv_cnt3 - r3), W'(1));
    chk("m3_underruns", W'(und_cnt3 - u3), W'(0));
    sclk = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] g1, g2;
    int r0, u0;
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0; sclk = 1'b0;
    r0 = rxv_cnt0; u0 = und_cnt0;
    load_tx(0, 8'hA5);
    exp_q0.push_back(8'h11);
    exp_q0.push_back(8'h22);
    start_frame();
    chk("b2b_ready_after_load", W'(tx_ready0), W'(1));
    load_tx(0, 8'h55);
    xfer(8'h11, 8, g1);
    xfer(8'h22, 8, g2);
    end_frame();
    chk("b2b_word1", g1, 8'hA5);
    chk("b2b_word2", g2, 8'h55);
    chk("b2b_rx_pulses", W'(rxv_cnt0 - r0), W'(2));
    chk("b2b_underruns", W'(und_cnt0 - u0), W'(0));
  endtask

  task automatic test_abort();
    logic [W-1:0] got;
    int r0, u0;
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0; sclk = 1'b0;
    r0 = rxv_cnt0; u0 = und_cnt0;
    load_tx(0, 8'hC3);
    start_frame();
    load_tx(0, 8'h99);
    xfer(8'hAB, 5, got);
    end_frame();
    chk("abort_partial_miso", got, 8'hC0);
    chk("abort_no_rx", W'(rxv_cnt0 - r0), W'(0));
    chk("abort_rx_hold", rx_data0, 8'h22);
    chk("abort_buf_kept", W'(tx_ready0), W'(0));
    exp_q0.push_back(8'hF0);
    start_frame();
    xfer(8'hF0, 8, got);
    end_frame();
    chk("abort_next_miso", got, 8'h99);
    chk("abort_next_rx", rx_data0, 8'hF0);
    chk("abort_rx_pulses", W'(rxv_cnt0 - r0), W'(1));
    chk("abort_underruns", W'(und_cnt0 - u0), W'(0));
  endtask

  task automatic test_underrun();
    logic [W-1:0] got;
    int r0, u0;
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0; sclk = 1'b0;
    r0 = rxv_cnt0; u0 = und_cnt0;
    chk("ur_buffer_empty", W'(tx_ready0), W'(1));
    exp_q0.push_back(8'h5A);
    start_frame();
    xfer(8'h5A, 8, got);
    end_frame();
    chk("ur_miso_zero", got, 8'h00);
    chk("ur_pulses", W'(und_cnt0 - u0), W'(1));
    chk("ur_rx_data", rx_data0, 8'h5A);
    chk("ur_rx_pulses", W'(rxv_cnt0 - r0), W'(1));
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    int r0;
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0; sclk = 1'b0;
    load_tx(0, 8'h3C);
    start_frame();
    xfer(8'hFF, 3, got);
    rst = 1'b1;
    #1;
    chk("rmid_ctl", W'({miso0, miso_oe0, tx_ready0, rx_valid0, busy0, und0}), W'(6'b001000));
    chk("rmid_rx", rx_data0, '0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    chk("rmid_wait_fall", W'(busy0), W'(0));
    ss0 = 1'b1;
    wait_clk(6);
    r0 = rxv_cnt0;
    load_tx(0, 8'h69);
    exp_q0.push_back(8'h96);
    start_frame();
    xfer(8'h96, 8, got);
    end_frame();
    chk("rmid_next_miso", got, 8'h69);
    chk("rmid_next_rx", rx_data0, 8'h96);
    chk("rmid_rx_pulses", W'(rxv_cnt0 - r0), W'(1));
  endtask

  initial begin
    sel = 0; cpol_m = 1'b0; cpha_m = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_reset_mid();
    chk("sb0_drained", W'(exp_q0.size()), W'(0));
    chk("sb3_drained", W'(exp_q3.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
